uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Serial receive engine for `com_uart`: recovers 8-bit frames from the `RX` line with 16x oversampling, optionally checks parity, and queues good bytes in a small FIFO for the CPU side. It is the line-facing counterpart of the UART transmitter. It exposes the `RX_flag`/`RX_use` handshake and the `data_bus_out` bus that `com_uart` drives to the CPU.

## Interface
- `CLK_FREQ`, 125_000_000, system clock frequency in Hz.
- `FIFO_DEPTH`, 4, receive FIFO entries (power of two, ≥2).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `RX` in 1: serial line, idle high.
- `RX_config_register` in 8: frame configuration.
  - [1:0] baud: 00=9600, 01=19200, 10=38400, 11=115200.
  - [2] parity enable.
  - [3] parity type: 1=odd, 0=even.
  - [4] stop bits: 1=two, 0=one.
  - [7:5] reserved, ignored.
- `RX_use` in 1: CPU read strobe; its rising edge pops one byte.
- `data_bus_out` out 8: FIFO head byte (first-word fall-through). Valid while `RX_flag`=1; 0 when empty.
- `RX_flag` out 1: FIFO not empty.
- `parity_err` out 1: one-cycle pulse when a byte is rejected for parity.
- `frame_err` out 1: one-cycle pulse when a byte is rejected for its stop bit.
- `overrun` out 1: sticky; set when a good byte is dropped because the FIFO is full.

## Operation
- `RX` passes through a 2-flop synchronizer before any use. Its reset value is 1.
- Tick generator:
  - `DIV = max(1, CLK_FREQ/(16*baud))`, integer floor.
  - It emits a one-clock `tick` every `DIV` clocks.
  - It free-runs and is reloaded to 0 on the IDLE→START transition.
- Config is latched on IDLE→START and held for the whole frame. Changing it mid-frame has no effect on that frame.
- FSM states and transitions:
  - IDLE: a synchronized falling edge (1→0) → START. Clear the tick and sample counters.
  - START: at sample 8 (mid-bit), line=0 → DATA. Line=1 → IDLE (glitch rejected, no error flag).
  - DATA: 8 bits, LSB first. Each bit is sampled at sample 8 of its bit period into a shift register. After bit 7: → PARITY if parity is enabled, else → STOP.
  - PARITY: sample at mid-bit, compare against XOR of the data bits. Even parity: data^p must be 0. Odd parity: data^p must be 1.
  - STOP: sample at mid-bit.
    - Stop=0 → frame error; the byte is discarded.
    - With two stop bits selected, the second stop bit is also checked. Either stop bit being 0 gives a frame error.
    - Frame error → BREAK; otherwise → IDLE.
  - BREAK: wait for the synchronized line to be 1, then → IDLE. No new start bit is detected during BREAK.
- Byte commit, one clock after the final stop-bit mid-sample:
  - Parity bad → `parity_err` pulse, no push.
  - Stop bad → `frame_err` pulse, no push. Parity and frame errors may pulse together.
  - Good and FIFO not full → push.
  - Good and FIFO full → drop the byte, set `overrun`.
- Pop: `RX_use` is registered, and a 0→1 transition pops when `RX_flag`=1. A high level held for any number of cycles pops exactly once. A pop on an empty FIFO is ignored.
- `overrun` clears on the next accepted pop.
- Push and pop in the same cycle:
  - Both complete and the count is unchanged.
  - When full, the pop frees the slot, so no overrun occurs.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is `log2(FIFO_DEPTH)+1` bits wide.

## Timing
- Reset values:
  - FSM IDLE; FIFO empty.
  - `RX_flag`=0, `data_bus_out`=0.
  - `parity_err`=0, `frame_err`=0, `overrun`=0.
- Asserting reset mid-frame aborts the frame immediately and flushes the FIFO. After release, the engine waits in IDLE for a fresh falling edge.
- Start detection latency: 2 clocks from `RX` falling edge, due to the synchronizer.
- `RX_flag` rises 2 clocks after the final stop-bit mid-sample tick: one clock for commit, one for the registered flag.
- `data_bus_out` updates to the next entry 1 clock after the registered `RX_use` edge is detected. `RX_flag` falls in the same cycle if the FIFO becomes empty.
- Error pulses are exactly 1 clock wide.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and checker are compiled in.
  - `RX_config_register[3:2]` are honoured.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA always → STOP.
  - Bits [3:2] are ignored, and a frame carrying a parity bit is received as a stop-bit sample.
  - `parity_err` is tied to 0.

## Test plan
- **Basic byte.** `CLK_FREQ`=1_843_200, config=8'h03 (115200, DIV=1). Send 8'hA5 (8N1). Required: `RX_flag`=1 and `data_bus_out`=8'hA5. Then pulse `RX_use`: `RX_flag`=0.
- **Parity.** `UART_RX_PARITY_EN` defined, config=8'h07 (even). Send 8'h55 with p=0: accepted. Send 8'h55 with p=1: one-cycle `parity_err`, FIFO unchanged.
- **Framing.** Config 8'h13 (two stop bits). Send 8'h3C with second stop=0: `frame_err` pulse, no push. Hold the line low 20 bits, then send 8'h01: 8'h01 is received.
- **Overrun.** `FIFO_DEPTH`=4. Send 8'h01 to 8'h05 without reading: `overrun`=1. Pops return 8'h01, 02, 03, 04 in order; `overrun` clears after the first pop.
- **Glitch and held strobe.** A 0.25-bit low glitch gives no byte and no error. Holding `RX_use` high for 10 clocks with 2 entries pops exactly 1.
- **Reset mid-frame.** Assert `rst_n`=0 during DATA bit 4 for 3 clocks. Required: all outputs at reset values. The following 8'hC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_engine.sv
// 16x-oversampled 8-bit UART receiver with a first-word-fall-through byte FIFO.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_engine #(
   parameter int CLK_FREQ   = 125_000_000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic [7:0] RX_config_register,
   input  logic       RX_use,
   output logic [7:0] data_bus_out,
   output logic       RX_flag,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
);

   function automatic int div_of(input int baud);
      int d;
      d = CLK_FREQ / (16 * baud);
      return (d < 1) ? 1 : d;
   endfunction

   localparam int DIV0  = div_of(9600);
   localparam int DIV1  = div_of(19200);
   localparam int DIV2  = div_of(38400);
   localparam int DIV3  = div_of(115200);
   localparam int CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
   logic [1:0]       baud_q, baud_d;
   logic             two_q, two_d;
   logic             pen_q, pen_d, odd_q, odd_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d, div_m1;
   logic             tick;
   logic [3:0]       samp_q, samp_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             stop2_q, stop2_d, pbad_q, pbad_d;
   logic             commit_q, commit_d;
   logic [7:0]       cbyte_q, cbyte_d;
   logic             cpbad_q, cpbad_d, cfbad_q, cfbad_d;
   logic             use_q, use_d, use_prev_q, use_prev_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [7:0]       data_q, data_d;
   logic             flag_q, flag_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic             push_req, pop, full, push, drop;
   logic [7:0]       mem_q [FIFO_DEPTH];

`ifdef UART_RX_PARITY_EN
   logic unused_cfg;
   assign unused_cfg = ^RX_config_register[7:5];
`else
   logic unused_cfg;
   assign unused_cfg = ^{RX_config_register[7:5], RX_config_register[3:2], pen_q, odd_q};
`endif

   always_comb begin
      case (baud_q)
         2'b00:   div_m1 = CNT_W'(DIV0 - 1);
         2'b01:   div_m1 = CNT_W'(DIV1 - 1);
         2'b10:   div_m1 = CNT_W'(DIV2 - 1);
         default: div_m1 = CNT_W'(DIV3 - 1);
      endcase
      tick = (tick_cnt_q == div_m1);
   end

   always_comb begin
      rx_meta_d  = RX;
      rx_sync_d  = rx_meta_q;
      rx_prev_d  = rx_sync_q;
      state_d    = state_q;
      baud_d     = baud_q;
      two_d      = two_q;
      pen_d      = pen_q;
      odd_d      = odd_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
      samp_d     = samp_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      stop2_d    = stop2_q;
      pbad_d     = pbad_q;
      commit_d   = 1'b0;
      cbyte_d    = cbyte_q;
      cpbad_d    = cpbad_q;
      cfbad_d    = cfbad_q;
      if (tick && state_q != S_IDLE && state_q != S_BREAK) samp_d = samp_q + 4'd1;
      // The start bit is checked at tick 8; every later bit lands 16 ticks on, where samp wraps.
      case (state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d    = S_START;
               baud_d     = RX_config_register[1:0];
               two_d      = RX_config_register[4];
               pen_d      = RX_config_register[2];
               odd_d      = RX_config_register[3];
               tick_cnt_d = '0;
               samp_d     = '0;
            end
         end
         S_START: begin
            if (tick && samp_q == 4'd7) begin
               samp_d  = '0;
               bit_d   = '0;
               stop2_d = 1'b0;
               pbad_d  = 1'b0;
               state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick && samp_q == 4'd15) begin
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = pen_q ? S_PARITY : S_STOP;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick && samp_q == 4'd15) begin
               pbad_d  = ((^shift_q) ^ rx_sync_q) != odd_q;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick && samp_q == 4'd15) begin
               if (!rx_sync_q || !two_q || stop2_q) begin
                  commit_d = 1'b1;
                  cbyte_d  = shift_q;
                  cpbad_d  = pbad_q;
                  cfbad_d  = !rx_sync_q;
                  state_d  = rx_sync_q ? S_IDLE : S_BREAK;
               end else begin
                  stop2_d = 1'b1;
               end
            end
         end
         S_BREAK: begin
            if (rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      use_d      = RX_use;
      use_prev_d = use_q;
      push_req   = commit_q && !cpbad_q && !cfbad_q;
      pop        = use_q && !use_prev_q && (count_q != '0);
      full       = (count_q == CW'(FIFO_DEPTH));
      push       = push_req && (!full || pop);
      drop       = push_req && full && !pop;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      flag_d     = (count_d != '0);
      // A byte written into the slot that becomes head must bypass the array.
      if (count_d == '0)                     data_d = 8'h00;
      else if (push && wr_ptr_q == rd_ptr_d) data_d = cbyte_q;
      else                                   data_d = mem_q[rd_ptr_d];
      ovr_d  = drop ? 1'b1 : (pop ? 1'b0 : ovr_q);
      perr_d = commit_q && cpbad_q;
      ferr_d = commit_q && cfbad_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         baud_q     <= 2'b11;
         two_q      <= 1'b0;
         pen_q      <= 1'b0;
         odd_q      <= 1'b0;
         tick_cnt_q <= '0;
         samp_q     <= '0;
         bit_q      <= '0;
         stop2_q    <= 1'b0;
         pbad_q     <= 1'b0;
         commit_q   <= 1'b0;
         cpbad_q    <= 1'b0;
         cfbad_q    <= 1'b0;
         use_q      <= 1'b0;
         use_prev_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_q     <= 8'h00;
         flag_q     <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         baud_q     <= baud_d;
         two_q      <= two_d;
         pen_q      <= pen_d;
         odd_q      <= odd_d;
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         stop2_q    <= stop2_d;
         pbad_q     <= pbad_d;
         commit_q   <= commit_d;
         cpbad_q    <= cpbad_d;
         cfbad_q    <= cfbad_d;
         use_q      <= use_d;
         use_prev_q <= use_prev_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_q     <= data_d;
         flag_q     <= flag_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      cbyte_q <= cbyte_d;
      if (push) mem_q[wr_ptr_q] <= cbyte_q;
   end

   assign data_bus_out = data_q;
   assign RX_flag      = flag_q;
   assign parity_err   = perr_q;
   assign frame_err    = ferr_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: stimulus queues expected bytes/error pulses,
// a monitor compares them as the DUT hands out bytes or pulses its error flags.
module tb_uart_rx_engine;

   localparam int BIT = 16;  // 1_843_200 Hz at 115200 baud gives DIV=1

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RX = 1'b1;
   logic [7:0] cfg = 8'h03;
   logic       RX_use = 1'b0;
   logic [7:0] data_bus_out;
   logic       RX_flag, parity_err, frame_err, overrun;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_bytes[$];
   logic [1:0] exp_errs[$];   // {parity_err, frame_err}
   logic       mon_use_prev = 1'b0;

   uart_rx_engine #(.CLK_FREQ(1_843_200), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .RX_config_register(cfg), .RX_use(RX_use),
      .data_bus_out(data_bus_out), .RX_flag(RX_flag), .parity_err(parity_err),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (RX_use && !mon_use_prev && RX_flag) begin
         if (exp_bytes.size() == 0) check("unexpected_byte", {24'h0, data_bus_out}, 32'h1ff);
         else check("rx_byte", {24'h0, data_bus_out}, {24'h0, exp_bytes.pop_front()});
      end
      mon_use_prev = RX_use;
      if (parity_err || frame_err) begin
         if (exp_errs.size() == 0) check("unexpected_err", {30'h0, parity_err, frame_err}, 32'h0);
         else check("err_pulse", {30'h0, parity_err, frame_err}, {30'h0, exp_errs.pop_front()});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic v);
      RX = v;
      idle(BIT);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit has_par, input logic pbit,
                             input bit two, input logic s2);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (has_par) send_bit(pbit);
      send_bit(1'b1);
      if (two) send_bit(s2);
      RX = 1'b1;
      idle(4);
   endtask

   task automatic read_byte();
      RX_use = 1'b1;
      idle(2);
      RX_use = 1'b0;
      idle(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      idle(3);
      check("rst_flag", {31'h0, RX_flag}, 32'h0);
      check("rst_data", {24'h0, data_bus_out}, 32'h0);
      check("rst_errs", {29'h0, parity_err, frame_err, overrun}, 32'h0);
      rst_n = 1'b1;
      idle(5);

      // basic 8N1 byte
      cfg = 8'h03;
      send_frame(8'hA5, 0, 1'b0, 0, 1'b1);
      check("basic_flag", {31'h0, RX_flag}, 32'h1);
      check("basic_data", {24'h0, data_bus_out}, 32'hA5);
      exp_bytes.push_back(8'hA5);
      read_byte();
      check("basic_flag_clr", {31'h0, RX_flag}, 32'h0);
      check("basic_data_clr", {24'h0, data_bus_out}, 32'h0);

      // parity byte
      cfg = 8'h07;
`ifdef UART_RX_PARITY_EN
      exp_bytes.push_back(8'h55);
      send_frame(8'h55, 1, 1'b0, 0, 1'b1);
      read_byte();
      exp_errs.push_back(2'b10);
      send_frame(8'h55, 1, 1'b1, 0, 1'b1);
      check("par_no_push", {31'h0, RX_flag}, 32'h1 ^ 32'h1);
`else
      exp_bytes.push_back(8'h55);
      send_frame(8'h55, 1, 1'b1, 0, 1'b1);
      check("nopar_flag", {31'h0, RX_flag}, 32'h1);
      read_byte();
`endif

      // framing error on second stop bit, then a long break
      cfg = 8'h13;
      exp_errs.push_back(2'b01);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(logic'((8'h3C >> i) & 8'h01));
      send_bit(1'b1);
      send_bit(1'b0);
      idle(20 * BIT);
      RX = 1'b1;
      idle(2 * BIT);
      check("frm_no_push", {31'h0, RX_flag}, 32'h0);
      send_frame(8'h01, 0, 1'b0, 1, 1'b1);
      check("frm_next_data", {24'h0, data_bus_out}, 32'h01);
      exp_bytes.push_back(8'h01);
      read_byte();

      // overrun
      cfg = 8'h03;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b0, 0, 1'b1);
      check("ovr_set", {31'h0, overrun}, 32'h1);
      for (int i = 1; i <= 4; i++) exp_bytes.push_back(8'(i));
      read_byte();
      check("ovr_clr", {31'h0, overrun}, 32'h0);
      check("ovr_head", {24'h0, data_bus_out}, 32'h02);
      repeat (3) read_byte();
      check("ovr_empty", {31'h0, RX_flag}, 32'h0);

      // quarter-bit glitch
      RX = 1'b0;
      idle(BIT / 4);
      RX = 1'b1;
      idle(3 * BIT);
      check("glitch_flag", {31'h0, RX_flag}, 32'h0);

      // held strobe pops once
      send_frame(8'h5A, 0, 1'b0, 0, 1'b1);
      send_frame(8'hE7, 0, 1'b0, 0, 1'b1);
      exp_bytes.push_back(8'h5A);
      RX_use = 1'b1;
      idle(10);
      RX_use = 1'b0;
      idle(3);
      check("held_flag", {31'h0, RX_flag}, 32'h1);
      check("held_head", {24'h0, data_bus_out}, 32'hE7);
      exp_bytes.push_back(8'hE7);
      read_byte();

      // reset during data bit 4 with a byte already queued
      send_frame(8'h77, 0, 1'b0, 0, 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(logic'((8'hC3 >> i) & 8'h01));
      RX = 1'b0;
      idle(BIT / 2);
      rst_n = 1'b0;
      idle(3);
      check("mid_rst_flag", {31'h0, RX_flag}, 32'h0);
      check("mid_rst_data", {24'h0, data_bus_out}, 32'h0);
      check("mid_rst_errs", {29'h0, parity_err, frame_err, overrun}, 32'h0);
      rst_n = 1'b1;
      RX = 1'b1;
      idle(2 * BIT);
      check("post_rst_flag", {31'h0, RX_flag}, 32'h0);
      send_frame(8'hC3, 0, 1'b0, 0, 1'b1);
      exp_bytes.push_back(8'hC3);
      read_byte();
      check("post_rst_empty", {31'h0, RX_flag}, 32'h0);

      idle(10);
      check("bytes_left", exp_bytes.size(), 32'h0);
      check("errs_left", exp_errs.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
